// File: rtl/iis_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iis_sched_pkg
// Description : Shared types and constants for the IIS effect scheduler:
//               FSM state encoding, default sample width, overrun counter
//               width and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iis_sched_pkg;

  // Default sample width used by the scheduler top level
  localparam int DATA_W_DEF = 16;

  // Width of the saturating overrun event counter
  localparam int OVR_CNT_W = 8;

  // Scheduler FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_L  = 3'd1,
    S_WAIT_L = 3'd2,
    S_REQ_R  = 3'd3,
    S_WAIT_R = 3'd4,
    S_UPDATE = 3'd5
  } sched_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    logic [OVR_CNT_W-1:0] r;
    r = (&v) ? v : (v + 1'b1);
    return r;
  endfunction

endpackage : iis_sched_pkg
`default_nettype wire

// File: rtl/strobe_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : strobe_edge_det
// Description : Registered rising-edge detector. The history register
//               resets to 0, so an input held high across reset release
//               yields exactly one rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic rise_o
);

  logic last_q;
  logic rise_q;

  // Track the previous input level and register a one-cycle rise pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      last_q <= in_i;
      rise_q <= in_i & ~last_q;
    end
  end

  assign rise_o = rise_q;

endmodule : strobe_edge_det
`default_nettype wire

// File: rtl/iis_effect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iis_effect_scheduler
// Description : Takes one stereo sample pair per valid strobe from the IIS
//               handler, sends L then R through a shared effect engine using
//               a req/ack + done handshake, and returns both results in one
//               update cycle. Bypass loops the held inputs straight back.
//               Strobes arriving while busy are dropped and counted.
//               Optional build macro IIS_SCHED_TIMEOUT_EN adds a per-request
//               watchdog that substitutes the raw sample on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module iis_effect_scheduler
  import iis_sched_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_strobe_i,
  input  logic [DATA_W-1:0]    smp_l_i,
  input  logic [DATA_W-1:0]    smp_r_i,
  output logic [DATA_W-1:0]    smp_l_o,
  output logic [DATA_W-1:0]    smp_r_o,
  input  logic                 bypass_i,
  output logic                 eff_req_o,
  output logic                 eff_ch_o,
  output logic [DATA_W-1:0]    eff_data_o,
  input  logic                 eff_ack_i,
  input  logic                 eff_done_i,
  input  logic [DATA_W-1:0]    eff_data_i,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic [OVR_CNT_W-1:0] ovr_cnt_o,
  output logic                 timeout_o,
  input  logic                 clr_i
);

  sched_state_e          state_q;
  logic [DATA_W-1:0]     hold_l_q, hold_r_q;
  logic [DATA_W-1:0]     res_l_q, res_r_q;
  logic [DATA_W-1:0]     smp_l_q, smp_r_q;
  logic                  eff_req_q;
  logic                  eff_ch_q;
  logic [DATA_W-1:0]     eff_data_q;
  logic                  overrun_q;
  logic [OVR_CNT_W-1:0]  ovr_cnt_q;

  logic w_rise;
  logic w_ovr;
  logic w_tmo_fire;

  strobe_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (valid_strobe_i),
    .rise_o (w_rise)
  );

  // A new sample that finds the scheduler busy is an overrun and is dropped
  assign w_ovr = w_rise && (state_q != S_IDLE);

`ifdef IIS_SCHED_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;
  logic             w_in_wd;
  logic             w_leave;

  assign w_in_wd = (state_q == S_REQ_L) || (state_q == S_WAIT_L) ||
                   (state_q == S_REQ_R) || (state_q == S_WAIT_R);
  assign w_tmo_fire = w_in_wd && (tmo_cnt_q == TMO_LIMIT);

  // Any exit from a REQ/WAIT state lands in a fresh state, so restarting on
  // exit is the same as restarting on entry
  assign w_leave = w_tmo_fire ||
                   (((state_q == S_REQ_L) || (state_q == S_REQ_R)) && eff_ack_i) ||
                   (((state_q == S_WAIT_L) || (state_q == S_WAIT_R)) && eff_done_i);

  // Per-state watchdog counter, cleared outside REQ/WAIT and on every exit
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !w_in_wd || w_leave) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Sticky watchdog flag; an explicit clear beats a simultaneous expiry
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (clr_i) begin
      timeout_q <= 1'b0;
    end else if (w_tmo_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo_fire   = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  // Scheduler FSM: sequences L then R through the engine, with registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      res_l_q    <= '0;
      res_r_q    <= '0;
      smp_l_q    <= '0;
      smp_r_q    <= '0;
      eff_req_q  <= 1'b0;
      eff_ch_q   <= 1'b0;
      eff_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_rise) begin
            hold_l_q <= smp_l_i;
            hold_r_q <= smp_r_i;
            if (bypass_i) begin
              res_l_q <= smp_l_i;
              res_r_q <= smp_r_i;
              state_q <= S_UPDATE;
            end else begin
              eff_req_q  <= 1'b1;
              eff_ch_q   <= 1'b0;
              eff_data_q <= smp_l_i;
              state_q    <= S_REQ_L;
            end
          end
        end

        S_REQ_L: begin
          if (eff_ack_i) begin
            eff_req_q <= 1'b0;
            state_q   <= S_WAIT_L;
          end else if (w_tmo_fire) begin
            res_l_q    <= hold_l_q;
            eff_req_q  <= 1'b1;
            eff_ch_q   <= 1'b1;
            eff_data_q <= hold_r_q;
            state_q    <= S_REQ_R;
          end
        end

        S_WAIT_L: begin
          if (eff_done_i || w_tmo_fire) begin
            res_l_q    <= eff_done_i ? eff_data_i : hold_l_q;
            eff_req_q  <= 1'b1;
            eff_ch_q   <= 1'b1;
            eff_data_q <= hold_r_q;
            state_q    <= S_REQ_R;
          end
        end

        S_REQ_R: begin
          if (eff_ack_i) begin
            eff_req_q <= 1'b0;
            state_q   <= S_WAIT_R;
          end else if (w_tmo_fire) begin
            res_r_q   <= hold_r_q;
            eff_req_q <= 1'b0;
            state_q   <= S_UPDATE;
          end
        end

        S_WAIT_R: begin
          if (eff_done_i || w_tmo_fire) begin
            res_r_q <= eff_done_i ? eff_data_i : hold_r_q;
            state_q <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          smp_l_q <= res_l_q;
          smp_r_q <= res_r_q;
          state_q <= S_IDLE;
        end

        default: begin
          eff_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag and saturating event count; clear wins on the flag,
  // while a coincident overrun leaves the count at one
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (clr_i) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= w_ovr ? OVR_CNT_W'(1) : '0;
    end else if (w_ovr) begin
      overrun_q <= 1'b1;
      ovr_cnt_q <= sat_inc(ovr_cnt_q);
    end
  end

  assign smp_l_o    = smp_l_q;
  assign smp_r_o    = smp_r_q;
  assign eff_req_o  = eff_req_q;
  assign eff_ch_o   = eff_ch_q;
  assign eff_data_o = eff_data_q;
  assign busy_o     = (state_q != S_IDLE);
  assign overrun_o  = overrun_q;
  assign ovr_cnt_o  = ovr_cnt_q;

endmodule : iis_effect_scheduler
`default_nettype wire

// File: tb/tb_iis_effect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_iis_effect_scheduler
// Description : Directed self-checking bench for iis_effect_scheduler with a
//               small effect-engine model (result = input + 1, done three
//               cycles after acceptance). Timeout expectations follow the
//               IIS_SCHED_TIMEOUT_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iis_effect_scheduler;

  localparam int DATA_W = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              valid_strobe_i = 1'b0;
  logic [DATA_W-1:0] smp_l_i = '0;
  logic [DATA_W-1:0] smp_r_i = '0;
  logic [DATA_W-1:0] smp_l_o, smp_r_o;
  logic              bypass_i = 1'b0;
  logic              eff_req_o, eff_ch_o;
  logic [DATA_W-1:0] eff_data_o;
  logic              eff_ack_i;
  logic              eff_done_i;
  logic [DATA_W-1:0] eff_data_i;
  logic              busy_o, overrun_o, timeout_o;
  logic [7:0]        ovr_cnt_o;
  logic              clr_i = 1'b0;

  // Engine model controls (driven by the stimulus block)
  logic              ack_en = 1'b1;
  logic [1:0]        done_mask = 2'b11;
  logic              spur_done = 1'b0;
  logic [DATA_W-1:0] spur_data = '0;

  // Engine model state (driven only by the engine process)
  logic              eng_done = 1'b0;
  logic [DATA_W-1:0] eng_data = '0;
  logic [DATA_W-1:0] eng_cap = '0;
  int                eng_wait = 0;
  int                log_n = 0;
  int                req_cycles = 0;
  logic              log_ch [64];
  logic [DATA_W-1:0] log_data [64];

  int n_cmp = 0;
  int n_err = 0;

  assign eff_ack_i  = ack_en;
  assign eff_done_i = eng_done | spur_done;
  assign eff_data_i = spur_done ? spur_data : eng_data;

  always #10 clk_i = ~clk_i;

  iis_effect_scheduler #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_strobe_i (valid_strobe_i),
    .smp_l_i        (smp_l_i),
    .smp_r_i        (smp_r_i),
    .smp_l_o        (smp_l_o),
    .smp_r_o        (smp_r_o),
    .bypass_i       (bypass_i),
    .eff_req_o      (eff_req_o),
    .eff_ch_o       (eff_ch_o),
    .eff_data_o     (eff_data_o),
    .eff_ack_i      (eff_ack_i),
    .eff_done_i     (eff_done_i),
    .eff_data_i     (eff_data_i),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .ovr_cnt_o      (ovr_cnt_o),
    .timeout_o      (timeout_o),
    .clr_i          (clr_i)
  );

  // Engine model: accept on req&ack, pulse done with input+1 three cycles later
  always @(negedge clk_i) begin
    eng_done = 1'b0;
    if (eff_req_o) req_cycles = req_cycles + 1;
    if (eng_wait > 0) begin
      eng_wait = eng_wait - 1;
      if (eng_wait == 0) begin
        eng_done = 1'b1;
        eng_data = eng_cap + 1'b1;
      end
    end else if (eff_req_o && eff_ack_i) begin
      if (log_n < 64) begin
        log_ch[log_n]   = eff_ch_o;
        log_data[log_n] = eff_data_o;
      end
      log_n = log_n + 1;
      if (done_mask[eff_ch_o]) begin
        eng_cap  = eff_data_o;
        eng_wait = 3;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // One high cycle then one low cycle; returns after the FSM has reacted
  task automatic pulse_strobe(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    smp_l_i = l;
    smp_r_i = r;
    valid_strobe_i = 1'b1;
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy_o && n < max) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int base;
    int req0;

    // Reset state
    do_reset();
    #1;
    check_val("rst_l",    smp_l_o,   32'h0);
    check_val("rst_r",    smp_r_o,   32'h0);
    check_val("rst_busy", busy_o,    32'h0);
    check_val("rst_req",  eff_req_o, 32'h0);
    check_val("rst_ovr",  overrun_o, 32'h0);
    check_val("rst_cnt",  ovr_cnt_o, 32'h0);
    check_val("rst_tmo",  timeout_o, 32'h0);

    // Normal engine transaction
    base = log_n;
    pulse_strobe(16'h1234, 16'hABCD);
    check_val("s1_busy", busy_o, 32'h1);
    wait_idle(100, "s1");
    check_val("s1_l",     smp_l_o, 32'h1235);
    check_val("s1_r",     smp_r_o, 32'hABCE);
    check_val("s1_nreq",  log_n - base, 32'd2);
    check_val("s1_ch0",   log_ch[base],     32'h0);
    check_val("s1_ch1",   log_ch[base + 1], 32'h1);
    check_val("s1_dat0",  log_data[base],     32'h1234);
    check_val("s1_dat1",  log_data[base + 1], 32'hABCD);
    check_val("s1_ovr",   overrun_o, 32'h0);

    // Spurious done while idle must be ignored
    spur_data = 16'hDEAD;
    spur_done = 1'b1;
    @(posedge clk_i); #1;
    spur_done = 1'b0;
    @(posedge clk_i); #1;
    check_val("spur_l",    smp_l_o, 32'h1235);
    check_val("spur_r",    smp_r_o, 32'hABCE);
    check_val("spur_busy", busy_o,  32'h0);

    // Bypass: outputs follow held inputs three cycles after the edge
    bypass_i = 1'b1;
    req0 = req_cycles;
    pulse_strobe(16'h8000, 16'h7FFF);
    check_val("byp_early", smp_l_o, 32'h1235);
    @(posedge clk_i); #1;
    check_val("byp_l", smp_l_o, 32'h8000);
    check_val("byp_r", smp_r_o, 32'h7FFF);
    wait_idle(10, "byp");
    check_val("byp_noreq", req_cycles - req0, 32'd0);
    bypass_i = 1'b0;

    // Second strobe during WAIT_L is dropped and counted
    pulse_strobe(16'h1111, 16'h2222);
    pulse_strobe(16'h5555, 16'h6666);
    wait_idle(100, "ovr");
    check_val("ovr_l",   smp_l_o,   32'h1112);
    check_val("ovr_r",   smp_r_o,   32'h2223);
    check_val("ovr_flg", overrun_o, 32'h1);
    check_val("ovr_cnt", ovr_cnt_o, 32'h1);

    // Many overruns against a stalled engine saturate the counter
    ack_en = 1'b0;
    pulse_strobe(16'h0001, 16'h0002);
    for (int i = 0; i < 300; i++) pulse_strobe(16'h0003, 16'h0004);
    check_val("sat_cnt", ovr_cnt_o, 32'd255);
    check_val("sat_flg", overrun_o, 32'h1);

    // Clear coinciding with an overrun: flag cleared, count restarts at one
    if (!busy_o) pulse_strobe(16'h0005, 16'h0006);
    valid_strobe_i = 1'b1;
    @(posedge clk_i); #1;
    valid_strobe_i = 1'b0;
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    check_val("clrovr_flg", overrun_o, 32'h0);
    check_val("clrovr_cnt", ovr_cnt_o, 32'h1);

    // Plain clear
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    check_val("clr_flg", overrun_o, 32'h0);
    check_val("clr_cnt", ovr_cnt_o, 32'h0);
    check_val("clr_tmo", timeout_o, 32'h0);
    do_reset();
    ack_en = 1'b1;

    // Engine accepts but never completes
    done_mask = 2'b00;
    pulse_strobe(16'h4321, 16'h8765);
`ifdef IIS_SCHED_TIMEOUT_EN
    wait_idle(200, "tmo");
    check_val("tmo_flg", timeout_o, 32'h1);
    check_val("tmo_l",   smp_l_o,   32'h4321);
    check_val("tmo_r",   smp_r_o,   32'h8765);
`else
    repeat (100) @(posedge clk_i);
    #1;
    check_val("hang_busy", busy_o,    32'h1);
    check_val("hang_tmo",  timeout_o, 32'h0);
`endif
    do_reset();

    // Reset while waiting on the right channel
    done_mask = 2'b01;
    pulse_strobe(16'h0F0F, 16'hF0F0);
    for (int i = 0; i < 50 && !(eff_req_o && eff_ch_o); i++) begin
      @(posedge clk_i); #1;
    end
    check_val("wr_reqr", {31'd0, eff_req_o && eff_ch_o}, 32'h1);
    @(posedge clk_i); #1;
    check_val("wr_inwait", busy_o, 32'h1);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check_val("wr_busy", busy_o,    32'h0);
    check_val("wr_req",  eff_req_o, 32'h0);
    check_val("wr_l",    smp_l_o,   32'h0);
    check_val("wr_r",    smp_r_o,   32'h0);
    rst_ni = 1'b1;
    done_mask = 2'b11;
    @(posedge clk_i); #1;
    pulse_strobe(16'h0F0F, 16'hF0F0);
    wait_idle(100, "post");
    check_val("post_l", smp_l_o, 32'h0F10);
    check_val("post_r", smp_r_o, 32'hF0F1);
    check_val("post_ovr", overrun_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_iis_effect_scheduler
`default_nettype wire

// File: doc/iis_effect_scheduler.md
IIS_EFFECT_SCHEDULER -- requirements
Module: iis_effect_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16, sample width
- TIMEOUT_CYCLES, 512, watchdog limit per channel request
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  system clock, 50 MHz
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- valid_strobe_i  in  1  sample-valid strobe from the IIS handler
- smp_l_i  in  DATA_W  left sample from the IIS handler
- smp_r_i  in  DATA_W  right sample from the IIS handler
- smp_l_o  out  DATA_W  left processed sample to the IIS handler
- smp_r_o  out  DATA_W  right processed sample to the IIS handler
- bypass_i  in  1  1 = skip the effect engine and loop the inputs straight back
- eff_req_o  out  1  request to the shared effect engine
- eff_ch_o  out  1  channel of the request: 0 = L, 1 = R
- eff_data_o  out  DATA_W  sample sent to the engine
- eff_ack_i  in  1  engine accepted the request
- eff_done_i  in  1  engine result valid, single-cycle pulse
- eff_data_i  in  DATA_W  engine result
- busy_o  out  1  scheduler not in IDLE
- overrun_o  out  1  sticky: a strobe arrived while busy
- ovr_cnt_o  out  8  count of overrun events, saturating
- timeout_o  out  1  sticky: the watchdog fired (only when the watchdog is compiled in)
- clr_i  in  1  clears overrun_o, ovr_cnt_o and timeout_o

Function
REQ-003 A rising edge of valid_strobe_i (registered edge detect) SHALL capture smp_l_i and smp_r_i into holding registers in the same cycle the edge is detected.
REQ-004 FSM states SHALL be IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPDATE.
REQ-005 IDLE SHALL go to REQ_L on a detected edge when bypass_i=0, and to UPDATE when bypass_i=1.
REQ-006 In REQ_L the block SHALL hold eff_req_o=1, eff_ch_o=0 and eff_data_o=held left sample stable until the cycle with eff_ack_i=1, then go to WAIT_L.
REQ-007 In WAIT_L, eff_done_i=1 SHALL latch eff_data_i as the left result and go to REQ_R; REQ_R/WAIT_R SHALL behave the same with eff_ch_o=1.
REQ-008 eff_done_i in any state other than WAIT_L/WAIT_R SHALL be ignored.
REQ-009 UPDATE SHALL register both results onto smp_l_o and smp_r_o in the same cycle, then return to IDLE (1 cycle).
REQ-010 In bypass, smp_l_o and smp_r_o SHALL equal the held inputs, 3 cycles after the strobe rising edge.
REQ-011 eff_req_o SHALL be 1 only in REQ_L/REQ_R; busy_o SHALL be 1 in every state except IDLE.
REQ-012 On an edge detected while not in IDLE (including UPDATE):
- overrun_o SHALL be set.
- ovr_cnt_o SHALL increment, saturating at 255.
- The new sample SHALL be dropped.
- The in-flight transaction SHALL continue unchanged.
REQ-013 When clr_i and an overrun occur in the same cycle, the clear SHALL win for overrun_o; ovr_cnt_o SHALL be set to 1.
REQ-014 A change of bypass_i SHALL take effect only at the next IDLE exit.

Reset
REQ-015 With rst_ni=0 at a clk_i edge, the block SHALL enter IDLE and zero all outputs, holding registers, counters and sticky flags.
REQ-016 Reset mid-transaction SHALL abandon the transaction; eff_req_o SHALL be 0 on the first cycle after reset.
REQ-017 The edge detector SHALL reset to "last=0", so a strobe held high through reset release produces one edge.

Configuration
REQ-018 With IIS_SCHED_TIMEOUT_EN defined:
- A counter SHALL run in REQ_x/WAIT_x and restart on each state entry.
- Reaching TIMEOUT_CYCLES-1 SHALL substitute the raw held sample as that channel's result, set timeout_o and advance as if done.
REQ-019 Without IIS_SCHED_TIMEOUT_EN, the block SHALL wait indefinitely, contain no counter logic, and tie timeout_o to 0.

Structure
REQ-020 Package iis_sched_pkg SHALL hold the state enum sched_state_e, the DATA_W default and the OVR_CNT_W=8 constant.
REQ-021 Strobe edge detection SHALL be a sub-module strobe_edge_det (clk_i, rst_ni, in, rise pulse).

Verification
REQ-022 Bench scenarios SHALL include:
- Strobe with L=0x1234, R=0xABCD, engine returns input+1 with ack=1 and done 3 cycles later -> smp_l_o=0x1235, smp_r_o=0xABCE; eff_ch_o sequence 0 then 1; overrun_o=0.
- bypass_i=1, L=0x8000, R=0x7FFF -> outputs equal the inputs 3 cycles after the edge; eff_req_o never 1.
- Second strobe edge during WAIT_L -> overrun_o=1, ovr_cnt_o=1, first-sample results correct; 300 overruns -> ovr_cnt_o=255; clr_i -> all 0.
- Macro defined, TIMEOUT_CYCLES=16, engine never asserts done -> timeout_o=1, smp_l_o/smp_r_o equal the raw inputs; macro undefined -> busy_o stays 1.
- rst_ni=0 asserted in WAIT_R -> next cycle IDLE, eff_req_o=0, outputs 0; next strobe processed normally.
- Spurious eff_done_i in IDLE with eff_data_i=0xDEAD -> outputs unchanged.
